// File: rtl/symbol_align_ctrl.sv
// Symbol alignment controller: sweeps delay_chain 0..15, measures one error window
// per delay after a settle period, then applies the delay with the fewest errors.
// Optional macro SYMBOL_ALIGN_TRACK_EN: keep measuring while locked, resweep on loss.
module symbol_align_ctrl #(
  parameter int WIN_LOG2    = 10,
  parameter int SETTLE      = 4,
  parameter int ACCEPT_ERRS = 8,
  parameter int LOSS_ERRS   = 64
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                sym_clk_ena,
  input  logic                sym_error,
  input  logic                start,
  output logic [3:0]          delay_chain,
  output logic                busy,
  output logic                locked,
  output logic                align_fail,
  output logic [WIN_LOG2:0]   best_errs
);

  // Error counts are one bit wider than the window index so a window with an
  // error on every symbol (count = 2^WIN_LOG2) still fits without saturation.
  localparam int CW = WIN_LOG2 + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [SW-1:0]       SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [WIN_LOG2-1:0] WIN_LAST    = '1;
  localparam logic [CW-1:0]       ACCEPT_LIM  = CW'(ACCEPT_ERRS);
  localparam logic [3:0]          DLY_LAST    = 4'd15;
`ifdef SYMBOL_ALIGN_TRACK_EN
  localparam logic [CW-1:0]       LOSS_LIM    = CW'(LOSS_ERRS);
`endif

  // Parameter sanity: a zero settle length has no meaning, and a loss limit
  // at or below the accept limit would declare loss on an accepted delay.
  if (SETTLE < 1) begin : g_bad_settle
    $error("SETTLE must be at least 1");
  end
  if (LOSS_ERRS <= ACCEPT_ERRS) begin : g_bad_loss
    $error("LOSS_ERRS must exceed ACCEPT_ERRS");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DECIDE,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          dly_nxt;
  logic                busy_nxt, locked_nxt, fail_nxt;
  logic [CW-1:0]       berrs_nxt;
  logic [CW-1:0]       min_errs, min_nxt;
  logic [3:0]          best_dly, best_nxt;
  logic [CW-1:0]       err_cnt, err_nxt;
  logic [WIN_LOG2-1:0] win_cnt, win_nxt;
  logic [SW-1:0]       settle_cnt, settle_nxt;
  logic [CW-1:0]       win_total;
  logic                restart;

  // Window error count including the symbol presented this cycle.
  always_comb begin
    win_total = err_cnt + {{(CW-1){1'b0}}, sym_error};
  end

  // State and datapath registers; reset wins over any simultaneous start.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      delay_chain <= '0;
      busy        <= 1'b0;
      locked      <= 1'b0;
      align_fail  <= 1'b0;
      best_errs   <= '0;
      min_errs    <= '1;
      best_dly    <= '0;
      err_cnt     <= '0;
      win_cnt     <= '0;
      settle_cnt  <= '0;
    end else begin
      state       <= state_nxt;
      delay_chain <= dly_nxt;
      busy        <= busy_nxt;
      locked      <= locked_nxt;
      align_fail  <= fail_nxt;
      best_errs   <= berrs_nxt;
      min_errs    <= min_nxt;
      best_dly    <= best_nxt;
      err_cnt     <= err_nxt;
      win_cnt     <= win_nxt;
      settle_cnt  <= settle_nxt;
    end
  end

  // Next-state and next-datapath logic; everything holds unless a state acts.
  always_comb begin
    state_nxt  = state;
    dly_nxt    = delay_chain;
    busy_nxt   = busy;
    locked_nxt = locked;
    fail_nxt   = align_fail;
    berrs_nxt  = best_errs;
    min_nxt    = min_errs;
    best_nxt   = best_dly;
    err_nxt    = err_cnt;
    win_nxt    = win_cnt;
    settle_nxt = settle_cnt;
    restart    = start;

    unique case (state)
      ST_IDLE: begin
      end

      // Discard symbols while the delay line output settles.
      ST_SETTLE: begin
        if (sym_clk_ena) begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_nxt = '0;
            err_nxt    = '0;
            win_nxt    = '0;
            state_nxt  = ST_MEASURE;
          end else begin
            settle_nxt = settle_cnt + SW'(1);
          end
        end
      end

      // Count errors over one window, then record a strictly better result so
      // that ties keep the lowest delay.
      ST_MEASURE: begin
        if (sym_clk_ena) begin
          err_nxt = win_total;
          if (win_cnt == WIN_LAST) begin
            win_nxt = '0;
            if (win_total < min_errs) begin
              min_nxt  = win_total;
              best_nxt = delay_chain;
            end
            if (delay_chain == DLY_LAST) begin
              state_nxt = ST_DECIDE;
            end else begin
              dly_nxt    = delay_chain + 4'd1;
              settle_nxt = '0;
              state_nxt  = ST_SETTLE;
            end
          end else begin
            win_nxt = win_cnt + WIN_LOG2'(1);
          end
        end
      end

      // Apply the best delay and judge it; counters are cleared so tracking
      // windows start aligned to the LOCKED entry.
      ST_DECIDE: begin
        dly_nxt   = best_dly;
        berrs_nxt = min_errs;
        busy_nxt  = 1'b0;
        err_nxt   = '0;
        win_nxt   = '0;
        if (min_errs <= ACCEPT_LIM) begin
          locked_nxt = 1'b1;
          state_nxt  = ST_LOCKED;
        end else begin
          fail_nxt  = 1'b1;
          state_nxt = ST_FAIL;
        end
      end

      ST_LOCKED: begin
`ifdef SYMBOL_ALIGN_TRACK_EN
        // Back-to-back windows at the fixed delay; a bad window forces a resweep.
        if (sym_clk_ena) begin
          if (win_cnt == WIN_LAST) begin
            win_nxt   = '0;
            err_nxt   = '0;
            berrs_nxt = win_total;
            if (win_total >= LOSS_LIM) begin
              restart = 1'b1;
            end
          end else begin
            win_nxt = win_cnt + WIN_LOG2'(1);
            err_nxt = win_total;
          end
        end
`endif
      end

      ST_FAIL: begin
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // A (re)start from any state begins a fresh sweep from delay 0.
    if (restart) begin
      state_nxt  = ST_SETTLE;
      dly_nxt    = '0;
      min_nxt    = '1;
      best_nxt   = '0;
      busy_nxt   = 1'b1;
      locked_nxt = 1'b0;
      fail_nxt   = 1'b0;
      err_nxt    = '0;
      win_nxt    = '0;
      settle_nxt = '0;
    end
  end

endmodule

// File: tb/tb_symbol_align_ctrl.sv
// Bench for symbol_align_ctrl: a channel model derives sym_error from the
// symbol index since start, a scoreboard holds the expected sweep result and a
// monitor checks it whenever busy falls.
module tb_symbol_align_ctrl;

  localparam int WL      = 4;
  localparam int ST      = 2;
  localparam int ACC     = 1;
  localparam int LOSS    = 4;
  localparam int NWIN    = 1 << WL;
  localparam int PER_DLY = ST + NWIN;
  localparam int SWEEP   = 16 * PER_DLY;

  logic          sys_clk = 1'b0;
  logic          reset;
  logic          sym_clk_ena;
  logic          sym_error;
  logic          start;
  logic [3:0]    delay_chain;
  logic          busy;
  logic          locked;
  logic          align_fail;
  logic [WL:0]   best_errs;

  symbol_align_ctrl #(
    .WIN_LOG2    (WL),
    .SETTLE      (ST),
    .ACCEPT_ERRS (ACC),
    .LOSS_ERRS   (LOSS)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .sym_clk_ena (sym_clk_ena),
    .sym_error   (sym_error),
    .start       (start),
    .delay_chain (delay_chain),
    .busy        (busy),
    .locked      (locked),
    .align_fail  (align_fail),
    .best_errs   (best_errs)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int dly;
    bit lck;
    bit fl;
    int be;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        last_exp;
  logic [15:0] mask [16];

  int n_checks     = 0;
  int n_fail       = 0;
  int n_done       = 0;
  int cyc          = 0;
  int sweep_sym    = 0;
  bit sweep_active = 1'b0;
  bit start_req    = 1'b0;
  bit hold_start   = 1'b0;
  bit post_rand    = 1'b0;
  bit post_val     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Expected sweep result: fewest window errors wins, lowest delay on ties.
  function automatic exp_t model();
    exp_t e;
    int   mn;
    int   bd;
    int   c;
    mn = 1 << 30;
    bd = 0;
    for (int d = 0; d < 16; d++) begin
      c = $countones(mask[d]);
      if (c < mn) begin
        mn = c;
        bd = d;
      end
    end
    e.dly = bd;
    e.be  = mn;
    e.lck = (mn <= ACC);
    e.fl  = (mn > ACC);
    return e;
  endfunction

  function automatic logic [15:0] rand_mask();
    logic [15:0] m;
    case ($urandom_range(0, 3))
      0:       m = 16'($urandom);
      1:       m = 16'($urandom) & 16'($urandom) & 16'($urandom);
      2:       m = 16'hFFFF;
      default: m = ($urandom_range(0, 1) == 1) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
    endcase
    return m;
  endfunction

  // Stimulus driver: one symbol every 4th cycle, start issued only on a
  // non-symbol cycle so symbol indices line up with the sweep.
  initial begin
    bit ena_n;
    int d;
    int p;
    start       = 1'b0;
    sym_clk_ena = 1'b0;
    sym_error   = 1'b0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      ena_n = (cyc % 4 == 0);
      start = hold_start;
      if (start_req && !ena_n) begin
        start     = 1'b1;
        start_req = 1'b0;
        exp_q.delete();
        exp_q.push_back(model());
        sweep_sym    = 0;
        sweep_active = 1'b1;
      end
      sym_clk_ena = ena_n;
      sym_error   = 1'($urandom_range(0, 1));
      if (ena_n) begin
        if (sweep_active && sweep_sym < SWEEP) begin
          d = sweep_sym / PER_DLY;
          p = sweep_sym % PER_DLY;
          check("delay_chain_in_sweep", delay_chain, d);
          sym_error = (p < ST) ? 1'($urandom_range(0, 1)) : mask[d][p-ST];
        end else begin
          sym_error = post_rand ? 1'($urandom_range(0, 1)) : post_val;
        end
        if (sweep_active) sweep_sym++;
      end
    end
  end

  // Monitor: a falling busy marks a finished sweep; compare with the scoreboard.
  initial begin
    bit   prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (reset) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !busy) begin
          n_done++;
          sweep_active = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e        = exp_q.pop_front();
            last_exp = e;
            check("done_delay_chain", delay_chain, e.dly);
            check("done_locked", locked, e.lck);
            check("done_align_fail", align_fail, e.fl);
            check("done_best_errs", best_errs, e.be);
            check("done_symbols", sweep_sym, SWEEP);
          end
        end
        prev_busy = busy;
      end
    end
  end

  task automatic wait_done(input string name);
    int n0;
    int k;
    n0 = n_done;
    k  = 0;
    while (n_done == n0 && k < 2000) begin
      @(posedge sys_clk);
      k++;
    end
    if (n_done == n0) check({name, "_timeout"}, 0, 1);
    repeat (2) @(posedge sys_clk);
  endtask

  task automatic run_sweep(input string name);
    start_req = 1'b1;
    wait_done(name);
  endtask

  task automatic wait_sym(input int target);
    int k;
    k = 0;
    while (!(sweep_active && sweep_sym >= target) && k < 2000) begin
      @(posedge sys_clk);
      k++;
    end
    check("reach_symbol", (sweep_active && sweep_sym >= target) ? 1 : 0, 1);
  endtask

  task automatic hold_check(input string name);
    repeat (100) @(posedge sys_clk);
    #1;
    check({name, "_hold_delay"}, delay_chain, last_exp.dly);
    check({name, "_hold_locked"}, locked, last_exp.lck);
    check({name, "_hold_fail"}, align_fail, last_exp.fl);
    check({name, "_hold_best"}, best_errs, last_exp.be);
    check({name, "_hold_busy"}, busy, 0);
  endtask

  task automatic fill_masks(input logic [15:0] v);
    for (int d = 0; d < 16; d++) mask[d] = v;
  endtask

  initial begin
    int k;
    reset = 1'b1;
    fill_masks(16'h0);

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_delay", delay_chain, 0);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_fail", align_fail, 0);
    check("rst_best", best_errs, 0);
    @(negedge sys_clk);
    reset = 1'b0;
    repeat (5) @(posedge sys_clk);

    // Only delay 6 is clean
    fill_masks(16'hFFFF);
    mask[6] = 16'h0;
    run_sweep("only_d6");
    hold_check("only_d6");

    // Delays 3 and 9 both clean: the lower one wins
    fill_masks(16'hFFFF);
    mask[3] = 16'h0;
    mask[9] = 16'h0;
    run_sweep("tie_d3_d9");

    // Errors everywhere: fail with a full-window count at delay 0
    fill_masks(16'hFFFF);
    run_sweep("all_err");
    post_rand = 1'b1;
    hold_check("all_err");
    post_rand = 1'b0;

    // Reset mid-measure with start held: everything returns to reset values
    for (int d = 0; d < 16; d++) mask[d] = rand_mask();
    start_req = 1'b1;
    wait_sym(3 * PER_DLY + 6);
    @(posedge sys_clk);
    #2;
    hold_start   = 1'b1;
    reset        = 1'b1;
    sweep_active = 1'b0;
    exp_q.delete();
    @(posedge sys_clk);
    #1;
    check("midrst_delay", delay_chain, 0);
    check("midrst_busy", busy, 0);
    check("midrst_locked", locked, 0);
    check("midrst_fail", align_fail, 0);
    check("midrst_best", best_errs, 0);
    #1;
    reset      = 1'b0;
    hold_start = 1'b0;
    repeat (40) @(posedge sys_clk);
    #1;
    check("after_rst_idle_busy", busy, 0);
    check("after_rst_idle_delay", delay_chain, 0);
    check("after_rst_idle_locked", locked, 0);

    // Random channels
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < 16; d++) mask[d] = rand_mask();
      if ($urandom_range(0, 1) == 1) mask[$urandom_range(0, 15)] = 16'h0;
      run_sweep("random");
    end

    // Restart while measuring at delay 5
    for (int d = 0; d < 16; d++) mask[d] = rand_mask();
    start_req = 1'b1;
    wait_sym(5 * PER_DLY + 5);
    check("pre_restart_delay", delay_chain, 5);
    for (int d = 0; d < 16; d++) mask[d] = rand_mask();
    start_req = 1'b1;
    k = 0;
    do begin
      @(posedge sys_clk);
      k++;
    end while (!start && k < 20);
    #1;
    check("restart_delay", delay_chain, 0);
    check("restart_busy", busy, 1);
    check("restart_locked", locked, 0);
    wait_done("restart");

`ifdef SYMBOL_ALIGN_TRACK_EN
    // Loss of lock while tracking forces a fresh sweep
    fill_masks(16'hFFFF);
    mask[3] = 16'h0;
    run_sweep("track_lock");
    post_val = 1'b1;
    k = 0;
    while (locked && k < 400) begin
      @(posedge sys_clk);
      #1;
      k++;
    end
    check("track_loss_locked", locked, 0);
    check("track_loss_busy", busy, 1);
    check("track_loss_delay", delay_chain, 0);
    post_val = 1'b0;
    @(negedge sys_clk);
    reset        = 1'b1;
    sweep_active = 1'b0;
    exp_q.delete();
    @(negedge sys_clk);
    reset = 1'b0;
`endif

    repeat (4) @(posedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/symbol_align_ctrl.md
SYMBOL_ALIGN_CTRL -- requirements
Module: symbol_align_ctrl

Interface
REQ-001 Parameter: WIN_LOG2, default 10, log2 of the measurement window length in symbols.
REQ-002 Parameter: SETTLE, default 4, number of symbols discarded after each delay_chain change.
REQ-003 Parameter: ACCEPT_ERRS, default 8, maximum window error count accepted as aligned.
REQ-004 Parameter: LOSS_ERRS, default 64, window error count that declares loss of lock (tracking only).
REQ-005 Port: sys_clk, input, 1, the only clock; all logic on the rising edge.
REQ-006 Port: reset, input, 1, synchronous active-high reset.
REQ-007 Port: sym_clk_ena, input, 1, symbol-rate enable; one symbol is counted per high cycle.
REQ-008 Port: sym_error, input, 1, comparator error flag, sampled only when sym_clk_ena=1.
REQ-009 Port: start, input, 1, single-cycle pulse that begins or restarts an alignment sweep.
REQ-010 Port: delay_chain, output, 4, delay selection driven to the symbol delay line.
REQ-011 Port: busy, output, 1, high while a sweep is in progress.
REQ-012 Port: locked, output, 1, high when the aligned delay is applied and accepted.
REQ-013 Port: align_fail, output, 1, high when the sweep finished with the best count above ACCEPT_ERRS.
REQ-014 Port: best_errs, output, WIN_LOG2+1, error count of the selected delay.

Function
REQ-015 FSM states: IDLE, SETTLE, MEASURE, DECIDE, LOCKED, FAIL.
REQ-016 IDLE->SETTLE on start; delay_chain:=0, the min register:=all ones, best delay:=0, busy:=1, locked:=0, align_fail:=0.
REQ-017 SETTLE: counts SETTLE symbols with sym_error ignored, then enters MEASURE with the error counter at 0.
REQ-018 MEASURE: counts 2^WIN_LOG2 symbols and increments the error counter on each symbol with sym_error=1; the counter does not saturate because its width is WIN_LOG2+1.
REQ-019 End of window: if count < min (strict), min:=count and best delay:=delay_chain, so ties keep the lowest delay.
REQ-020 End of window with delay_chain<15: delay_chain increments on the same cycle and the FSM returns to SETTLE.
REQ-021 End of window with delay_chain=15: the FSM enters DECIDE for exactly one cycle.
REQ-022 DECIDE: delay_chain:=best delay, best_errs:=min, busy:=0 on the next edge.
REQ-023 DECIDE exit: min<=ACCEPT_ERRS goes to LOCKED (locked:=1); otherwise FAIL (align_fail:=1).
REQ-024 Sweep length is 16*(SETTLE+2^WIN_LOG2) symbols plus 2 sys_clk cycles from the start edge to locked or align_fail.
REQ-025 start in any state, including mid-sweep, restarts the sweep per REQ-016 on the next edge.
REQ-026 LOCKED and FAIL hold all outputs until start or reset.
REQ-027 Symbol and window counters advance only on sym_clk_ena=1 cycles; sym_error is ignored when sym_clk_ena=0.

Reset
REQ-028 reset=1 on an edge forces IDLE with delay_chain=0, busy=0, locked=0, align_fail=0, best_errs=0, and all counters cleared.
REQ-029 reset overrides a simultaneous start, and reset mid-sweep abandons the sweep without any DECIDE.

Configuration
REQ-030 Macro SYMBOL_ALIGN_TRACK_EN: when defined, LOCKED runs continuous back-to-back windows at the fixed delay_chain, with no settle period.
REQ-031 With SYMBOL_ALIGN_TRACK_EN defined, best_errs updates with each tracking window's count.
REQ-032 With SYMBOL_ALIGN_TRACK_EN defined, a window count >= LOSS_ERRS clears locked and restarts the sweep per REQ-016.
REQ-033 When SYMBOL_ALIGN_TRACK_EN is undefined, no tracking logic exists and LOCKED is static per REQ-026.

Verification (WIN_LOG2=4, SETTLE=2, ACCEPT_ERRS=1, LOSS_ERRS=4, sym_clk_ena every 4th cycle)
REQ-034 Errors on every symbol unless delay_chain=6, then start -> after 288 symbols plus 2 cycles, delay_chain=6, locked=1, best_errs=0, busy=0.
REQ-035 Zero errors at delays 3 and 9 only -> delay_chain=3, locked=1.
REQ-036 sym_error held at 1 for all delays -> align_fail=1, locked=0, best_errs=16, delay_chain=0.
REQ-037 start pulsed while delay_chain=5 in MEASURE -> delay_chain=0 and state SETTLE on the next edge, followed by a full 288-symbol sweep.
REQ-038 reset pulsed mid-MEASURE with start held high -> all outputs equal their REQ-028 values on the next edge and the FSM stays in IDLE.
REQ-039 With SYMBOL_ALIGN_TRACK_EN defined, after lock inject 4 errors in one window -> locked=0, busy=1, delay_chain=0 at that window end.
